// File: rtl/z80_bus_initiator.sv
// rtl/z80_bus_initiator.sv - Z80-style bus cycle generator for the CPC expansion bus
//
// Runs one memory or I/O bus cycle per accepted command. The strobe sequence
// follows the Z80 T-state pattern, honours READY wait states, and adds a
// refresh phase after M1 opcode fetches.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_type              00 mem rd, 01 mem wr, 10 io rd, 11 io wr
//   cmd_m1                memory read is an opcode fetch
//   cmd_adr, cmd_data     cycle address and write data
//   rsp_valid             one-cycle pulse on completion
//   rsp_data, rsp_err     read data (held until next read) and timeout flag
//   adr, data_out/oe      bus address, write data and drive enable
//   data_in               bus read data
//   mreq_b .. rfsh_b      active-low bus strobes
//   ready                 low requests a wait state
module z80_bus_initiator #(
    parameter int         MAX_WAIT = 255,
    parameter logic [7:0] I_REG    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic        cmd_m1,
    input  logic [15:0] cmd_adr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [15:0] adr,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        mreq_b,
    output logic        iorq_b,
    output logic        rd_b,
    output logic        wr_b,
    output logic        m1_b,
    output logic        rfsh_b,
    input  logic        ready
);

    // Wait counter only needs to reach MAX_WAIT-1 before the abort decision.
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_GAP, S_T3, S_T4
    } state_t;

    state_t            state;
    logic [1:0]        typ;
    logic              m1_cyc;
    logic [7:0]        r_reg;
    logic [7:0]        rd_cap;
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            typ       <= 2'b00;
            m1_cyc    <= 1'b0;
            r_reg     <= 8'h00;
            rd_cap    <= 8'h00;
            wait_cnt  <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 8'h00;
            adr       <= 16'h0000;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            mreq_b    <= 1'b1;
            iorq_b    <= 1'b1;
            rd_b      <= 1'b1;
            wr_b      <= 1'b1;
            m1_b      <= 1'b1;
            rfsh_b    <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state     <= S_T1;
                        typ       <= cmd_type;
                        m1_cyc    <= cmd_m1 && (cmd_type == 2'b00);
                        cmd_ready <= 1'b0;
                        adr       <= cmd_adr;
                        if (cmd_type[0]) begin
                            data_out <= cmd_data;
                            data_oe  <= 1'b1;
                        end
                        // Memory cycles assert MREQ (and RD for reads) from T1;
                        // I/O cycles show only the address in T1.
                        if (!cmd_type[1]) begin
                            mreq_b <= 1'b0;
                            if (!cmd_type[0]) begin
                                rd_b <= 1'b0;
                                m1_b <= ~cmd_m1;
                            end
                        end
                    end
                end
                S_T1: begin
                    state <= S_T2;
                    if (typ[1]) begin
                        iorq_b <= 1'b0;
                        if (typ[0]) wr_b <= 1'b0;
                        else        rd_b <= 1'b0;
                    end else if (typ[0]) begin
                        wr_b <= 1'b0;
                    end
                end
                S_T2: begin
                    if (typ[1]) begin
                        state <= S_TWA;
                    end else if (!ready) begin
                        state    <= S_TW;
                        wait_cnt <= '0;
                    end else if (m1_cyc) begin
                        // Fetch data is taken here; MREQ drops out for one edge.
                        rd_cap <= data_in;
                        mreq_b <= 1'b1;
                        rd_b   <= 1'b1;
                        m1_b   <= 1'b1;
                        state  <= S_GAP;
                    end else begin
                        state <= S_T3;
                    end
                end
                S_TWA: begin
                    if (!ready) begin
                        state    <= S_TW;
                        wait_cnt <= '0;
                    end else begin
                        state <= S_T3;
                    end
                end
                S_TW: begin
                    if (ready) begin
                        if (m1_cyc) begin
                            rd_cap <= data_in;
                            mreq_b <= 1'b1;
                            rd_b   <= 1'b1;
                            m1_b   <= 1'b1;
                            state  <= S_GAP;
                        end else begin
                            state <= S_T3;
                        end
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        // Device never released READY: abandon with an error.
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        data_oe   <= 1'b0;
                        mreq_b    <= 1'b1;
                        iorq_b    <= 1'b1;
                        rd_b      <= 1'b1;
                        wr_b      <= 1'b1;
                        m1_b      <= 1'b1;
                        rfsh_b    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_GAP: begin
                    state  <= S_T3;
                    adr    <= {I_REG, r_reg};
                    mreq_b <= 1'b0;
                    rfsh_b <= 1'b0;
                end
                S_T3: begin
                    if (m1_cyc) begin
                        state  <= S_T4;
                        mreq_b <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        if (!typ[0]) rsp_data <= data_in;
                        data_oe   <= 1'b0;
                        mreq_b    <= 1'b1;
                        iorq_b    <= 1'b1;
                        rd_b      <= 1'b1;
                        wr_b      <= 1'b1;
                    end
                end
                S_T4: begin
                    state      <= S_IDLE;
                    cmd_ready  <= 1'b1;
                    rsp_valid  <= 1'b1;
                    rsp_data   <= rd_cap;
                    rfsh_b     <= 1'b1;
                    // R[7] is software-owned; only the low seven bits count.
                    r_reg[6:0] <= r_reg[6:0] + 7'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_initiator.sv
// tb/tb_z80_bus_initiator.sv - scoreboard bench for z80_bus_initiator
module tb_z80_bus_initiator;

    localparam int         MAX_WAIT = 4;
    localparam logic [7:0] I_REG    = 8'h00;

    localparam int P_T1  = 0;
    localparam int P_T2  = 1;
    localparam int P_TWA = 2;
    localparam int P_TW  = 3;
    localparam int P_G   = 4;
    localparam int P_T3  = 5;
    localparam int P_T3R = 6;
    localparam int P_T4R = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic        cmd_m1;
    logic [15:0] cmd_adr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [15:0] adr;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;
    logic        mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b;
    logic        ready;

    z80_bus_initiator #(.MAX_WAIT(MAX_WAIT), .I_REG(I_REG)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_m1(cmd_m1), .cmd_adr(cmd_adr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .adr(adr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b),
        .m1_b(m1_b), .rfsh_b(rfsh_b), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  ctl;
        logic [15:0] adr;
        logic [7:0]  dout;
        logic        chk_dout;
        logic [7:0]  rdat;
    } bus_t;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         acc;
        int         lat;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [7:0]  r_model;
    logic [7:0]  last_rd;
    logic [7:0]  last_dout;
    logic [15:0] last_adr;
    logic        next_rv, next_re, post_rst;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: per-cycle bus expectations and completion responses.
    always @(negedge clk) begin
        bus_t       e;
        rsp_t       r;
        logic [9:0] act;
        if (bus_q.size() > 0) begin
            e   = bus_q.pop_front();
            act = {mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, data_oe, cmd_ready, rsp_valid, rsp_err};
            checks++;
            if (act !== e.ctl || adr !== e.adr || rsp_data !== e.rdat ||
                (e.chk_dout && data_out !== e.dout)) begin
                errors++;
                $display("FAIL bus cyc=%0d ctl act=%b req=%b adr act=%h req=%h rsp_data act=%h req=%h dout act=%h req=%h",
                         cyc, act, e.ctl, adr, e.adr, rsp_data, e.rdat, data_out, e.dout);
            end
        end
        if (rsp_valid === 1'b1) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected cyc=%0d act rsp_valid=1 req none", cyc);
            end else begin
                r = rsp_q.pop_front();
                if (rsp_err !== r.err || rsp_data !== r.data || (cyc - r.acc) != r.lat) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d err act=%b req=%b data act=%h req=%h latency act=%0d req=%0d",
                             cyc, rsp_err, r.err, rsp_data, r.data, cyc - r.acc, r.lat);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bus_t phase_exp(input logic [1:0] t, input logic m1e, input int p,
                                       input logic [15:0] a, input logic [7:0] d,
                                       input logic [15:0] radr);
        bus_t e;
        logic mreq = 1'b1, iorq = 1'b1, rd = 1'b1, wr = 1'b1, m1 = 1'b1, rfsh = 1'b1;
        logic oe = t[0];
        logic [15:0] ea = a;
        case (p)
            P_G: ;
            P_T3R: begin mreq = 1'b0; rfsh = 1'b0; ea = radr; end
            P_T4R: begin rfsh = 1'b0; ea = radr; end
            default: begin
                if (!t[1]) begin
                    mreq = 1'b0;
                    if (!t[0]) begin
                        rd = 1'b0;
                        if (m1e) m1 = 1'b0;
                    end else if (p != P_T1) begin
                        wr = 1'b0;
                    end
                end else if (p != P_T1) begin
                    iorq = 1'b0;
                    if (t[0]) wr = 1'b0;
                    else      rd = 1'b0;
                end
            end
        endcase
        e.ctl      = {mreq, iorq, rd, wr, m1, rfsh, oe, 3'b000};
        e.adr      = ea;
        e.dout     = d;
        e.chk_dout = oe;
        e.rdat     = 8'h00;
        return e;
    endfunction

    task automatic push_idle();
        bus_t e;
        e.ctl      = {6'b111111, 1'b0, 1'b1, next_rv, next_re};
        e.adr      = last_adr;
        e.dout     = last_dout;
        e.chk_dout = post_rst;
        e.rdat     = last_rd;
        bus_q.push_back(e);
        next_rv = 1'b0;
        next_re = 1'b0;
    endtask

    task automatic randomize_idle_inputs();
        cmd_type = 2'($urandom);
        cmd_m1   = 1'($urandom);
        cmd_adr  = 16'($urandom);
        cmd_data = 8'($urandom);
        data_in  = 8'($urandom);
        ready    = 1'($urandom);
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'b0;
        randomize_idle_inputs();
        push_idle();
        step();
    endtask

    // n_low: ready-low samples before ready returns high (> MAX_WAIT times out).
    // rst_at: phase index at which reset is asserted, or -1.
    task automatic run_cmd(input logic [1:0] t, input logic m1, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] din,
                           input int n_low, input int rst_at);
        int          ph[$];
        int          fs;
        int          ntw;
        bit          to;
        logic        m1e;
        logic [15:0] radr;
        rsp_t        r;
        bus_t        e;
        m1e  = m1 && (t == 2'b00);
        to   = (n_low > MAX_WAIT);
        ntw  = to ? MAX_WAIT : n_low;
        radr = {I_REG, r_model};
        ph.push_back(P_T1);
        ph.push_back(P_T2);
        fs = 1;
        if (t[1]) begin
            ph.push_back(P_TWA);
            fs = 2;
        end
        for (int i = 0; i < ntw; i++) ph.push_back(P_TW);
        if (!to) begin
            if (m1e) begin
                ph.push_back(P_G);
                ph.push_back(P_T3R);
                ph.push_back(P_T4R);
            end else begin
                ph.push_back(P_T3);
            end
        end

        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_m1    = m1;
        cmd_adr   = a;
        cmd_data  = d;
        data_in   = din;
        ready     = 1'($urandom);
        if (rst_at < 0) begin
            r.err  = to;
            r.data = (!to && !t[0]) ? din : last_rd;
            r.acc  = cyc;
            r.lat  = ph.size() + 1;
            rsp_q.push_back(r);
        end
        push_idle();
        post_rst = 1'b0;
        step();

        cmd_valid = 1'b0;
        cmd_type  = 2'($urandom);
        cmd_m1    = 1'($urandom);
        cmd_adr   = 16'($urandom);
        cmd_data  = 8'($urandom);
        for (int i = 0; i < ph.size(); i++) begin
            if (i < fs)                 ready = 1'($urandom);
            else if (i < fs + n_low)    ready = 1'b0;
            else if (i == fs + n_low)   ready = 1'b1;
            else                        ready = 1'($urandom);
            e      = phase_exp(t, m1e, ph[i], a, d, radr);
            e.rdat = last_rd;
            bus_q.push_back(e);
            last_adr = e.adr;
            if (i == rst_at) begin
                reset = 1'b1;
                step();
                reset     = 1'b0;
                r_model   = 8'h00;
                last_rd   = 8'h00;
                last_adr  = 16'h0000;
                last_dout = 8'h00;
                post_rst  = 1'b1;
                return;
            end
            step();
        end
        if (t[0]) last_dout = d;
        if (!to && !t[0]) last_rd = din;
        if (m1e && !to) r_model = {r_model[7], r_model[6:0] + 7'd1};
        next_rv = 1'b1;
        next_re = to;
    endtask

    task automatic run_random();
        run_cmd(2'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, MAX_WAIT + 1), -1);
        if ($urandom_range(0, 3) == 0) idle_cycle();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        randomize_idle_inputs();
        r_model   = 8'h00;
        last_rd   = 8'h00;
        last_dout = 8'h00;
        last_adr  = 16'h0000;
        next_rv   = 1'b0;
        next_re   = 1'b0;
        post_rst  = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Bank-select I/O write, then a read with two wait states.
        run_cmd(2'b11, 1'b0, 16'h7F00, 8'hC4, 8'h00, 0, -1);
        run_cmd(2'b00, 1'b0, 16'h4000, 8'h00, 8'h5A, 2, -1);
        idle_cycle();

        // Opcode fetches until R wraps from 7F to 00.
        for (int i = 0; i < 129; i++)
            run_cmd(2'b00, 1'b1, 16'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 2), -1);

        run_cmd(2'b01, 1'b0, 16'hC000, 8'h11, 8'h00, 0, -1);

        // Wait limits: longest legal wait, then timeouts of each kind.
        run_cmd(2'b00, 1'b0, 16'h1234, 8'h00, 8'hA5, MAX_WAIT, -1);
        run_cmd(2'b00, 1'b0, 16'h2345, 8'h00, 8'h3C, MAX_WAIT + 1, -1);
        run_cmd(2'b10, 1'b0, 16'h7FAA, 8'h00, 8'h77, MAX_WAIT, -1);
        run_cmd(2'b11, 1'b0, 16'h7F55, 8'hE1, 8'h00, MAX_WAIT + 1, -1);
        run_cmd(2'b00, 1'b1, 16'h0100, 8'h00, 8'h99, MAX_WAIT + 1, -1);
        idle_cycle();

        for (int i = 0; i < 150; i++) run_random();

        // Reset in the first TW of an I/O read, then normal traffic.
        run_cmd(2'b10, 1'b0, 16'hBC00, 8'h00, 8'h42, 3, 3);
        run_cmd(2'b00, 1'b1, 16'h0038, 8'h00, 8'hC3, 0, -1);
        for (int i = 0; i < 10; i++) run_random();

        idle_cycle();
        idle_cycle();
        @(negedge clk);
        #1;
        checks++;
        if (rsp_q.size() != 0 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL drain rsp_q act=%0d bus_q act=%0d req=0", rsp_q.size(), bus_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
